// File: rtl/chebyshev_pkg.sv
// ============================================================================
// chebyshev_pkg : FSM state encoding and width helpers for chebyshev_feeder
// Rev 1.0
// ============================================================================
`default_nettype none

package chebyshev_pkg;

   localparam int COEFF_ADDR_W = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FEED    = 2'd1,
      S_WAIT    = 2'd2,
      S_CAPTURE = 2'd3
   } state_t;

   function automatic int out_width(input int wl, input int cl, input int widening);
      return 2 * wl + cl + widening;
   endfunction

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/chebyshev_feeder_if.sv
// ============================================================================
// chebyshev_feeder_if : control, table-write and compute-feed signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface chebyshev_feeder_if #(
   parameter int WL       = 4,
   parameter int CL       = 4,
   parameter int WIDENING = 0
);
   import chebyshev_pkg::*;

   localparam int OUT = out_width(WL, CL, WIDENING);

   logic                        start;
   logic signed [WL-1:0]        x_in;
   logic                        coeff_we;
   logic [COEFF_ADDR_W-1:0]     coeff_addr;
   logic signed [CL-1:0]        coeff_wdata;
   logic signed [WL-1:0]        data_out;
   logic signed [CL-1:0]        coeff_out;
   logic                        feed_valid;
   logic signed [OUT-1:0]       result_in;
   logic signed [OUT-1:0]       result;
   logic                        busy;
   logic                        done;

   modport master (
      output start, x_in, coeff_we, coeff_addr, coeff_wdata, result_in,
      input  data_out, coeff_out, feed_valid, result, busy, done
   );

   modport slave (
      input  start, x_in, coeff_we, coeff_addr, coeff_wdata, result_in,
      output data_out, coeff_out, feed_valid, result, busy, done
   );

endinterface

`default_nettype wire

// File: rtl/chebyshev_coeff_regfile.sv
// ============================================================================
// chebyshev_coeff_regfile : N_COEFF x CL coefficient table, 1 write, 1 async read
// Rev 1.0
// ============================================================================
`default_nettype none

module chebyshev_coeff_regfile
   import chebyshev_pkg::*;
#(
   parameter int CL      = 4,
   parameter int N_COEFF = 4
) (
   input  wire logic                    clk_i,
   input  wire logic                    rst_i,
   input  wire logic                    we_i,
   input  wire logic [COEFF_ADDR_W-1:0] waddr_i,
   input  wire logic signed [CL-1:0]    wdata_i,
   input  wire logic [COEFF_ADDR_W-1:0] raddr_i,
   output logic signed [CL-1:0]         rdata_o
);

   logic signed [CL-1:0] mem_q [N_COEFF];

   // Addresses beyond the table simply match no entry and are dropped.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < N_COEFF; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         for (int i = 0; i < N_COEFF; i++) begin
            if (waddr_i == COEFF_ADDR_W'(i)) begin
               mem_q[i] <= wdata_i;
            end
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int i = 0; i < N_COEFF; i++) begin
         if (raddr_i == COEFF_ADDR_W'(i)) begin
            rdata_o = mem_q[i];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/chebyshev_feeder.sv
// ============================================================================
// chebyshev_feeder : streams x and coefficients N-1..0 to a Clenshaw core, captures result
// Rev 1.0
// ============================================================================
`default_nettype none

module chebyshev_feeder
   import chebyshev_pkg::*;
#(
   parameter int WL       = 4,
   parameter int CL       = 4,
   parameter int WIDENING = 0,
   parameter int N_COEFF  = 4,
   parameter int LAT      = 2
) (
   input  wire logic         clk_i,
   input  wire logic         rst_i,
   chebyshev_feeder_if.slave bus
);

   localparam int OUT    = out_width(WL, CL, WIDENING);
   localparam int CNT_W  = cnt_width(N_COEFF);
   localparam int WAIT_W = (LAT > 1) ? $clog2(LAT) : 1;

   state_t                  state_q;
   logic [CNT_W-1:0]        idx_q;
   logic [WAIT_W-1:0]       wait_q;
   logic signed [WL-1:0]    data_q;
   logic signed [CL-1:0]    coeff_q;
   logic                    feed_valid_q;
   logic signed [OUT-1:0]   result_q;
   logic                    busy_q;
   logic                    done_q;

   logic                    rf_we_d;
   logic [COEFF_ADDR_W-1:0] rd_addr_d;
   logic signed [CL-1:0]    rd_data_d;
   logic signed [CL-1:0]    first_coeff_d;

   assign rf_we_d = bus.coeff_we && (state_q == S_IDLE);

   always_comb begin
      rd_addr_d = COEFF_ADDR_W'(N_COEFF - 1);
      if (state_q == S_FEED) begin
         rd_addr_d = COEFF_ADDR_W'(idx_q - CNT_W'(1));
      end
   end

   // A write landing in the start cycle must be seen by the very first term.
   always_comb begin
      first_coeff_d = rd_data_d;
      if (rf_we_d && (bus.coeff_addr == COEFF_ADDR_W'(N_COEFF - 1))) begin
         first_coeff_d = bus.coeff_wdata;
      end
   end

   chebyshev_coeff_regfile #(
      .CL      (CL),
      .N_COEFF (N_COEFF)
   ) u_regfile (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (rf_we_d),
      .waddr_i (bus.coeff_addr),
      .wdata_i (bus.coeff_wdata),
      .raddr_i (rd_addr_d),
      .rdata_o (rd_data_d)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         wait_q       <= '0;
         data_q       <= '0;
         coeff_q      <= '0;
         feed_valid_q <= 1'b0;
         result_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q      <= S_FEED;
                  busy_q       <= 1'b1;
                  data_q       <= bus.x_in;
                  coeff_q      <= first_coeff_d;
                  feed_valid_q <= 1'b1;
                  idx_q        <= CNT_W'(N_COEFF - 1);
               end
            end
            S_FEED: begin
               if (idx_q == '0) begin
                  feed_valid_q <= 1'b0;
                  data_q       <= '0;
                  coeff_q      <= '0;
                  if (LAT == 0) begin
                     state_q  <= S_CAPTURE;
                     result_q <= bus.result_in;
                     done_q   <= 1'b1;
                  end else begin
                     state_q <= S_WAIT;
                     wait_q  <= WAIT_W'(LAT - 1);
                  end
               end else begin
                  idx_q   <= idx_q - CNT_W'(1);
                  coeff_q <= rd_data_d;
               end
            end
            S_WAIT: begin
               if (wait_q == '0) begin
                  state_q  <= S_CAPTURE;
                  result_q <= bus.result_in;
                  done_q   <= 1'b1;
               end else begin
                  wait_q <= wait_q - WAIT_W'(1);
               end
            end
            S_CAPTURE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.data_out   = data_q;
   assign bus.coeff_out  = coeff_q;
   assign bus.feed_valid = feed_valid_q;
   assign bus.result     = result_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_chebyshev_feeder.sv
// ============================================================================
// tb_chebyshev_feeder : randomized self-checking bench for chebyshev_feeder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_chebyshev_feeder;
   import chebyshev_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   logic signed [3:0] tab [4];
   logic signed [3:0] tab1;

   always #5 clk = ~clk;

   chebyshev_feeder_if #(.WL(4), .CL(4), .WIDENING(0)) bus  ();
   chebyshev_feeder_if #(.WL(4), .CL(4), .WIDENING(0)) bus1 ();

   chebyshev_feeder #(.WL(4), .CL(4), .WIDENING(0), .N_COEFF(4), .LAT(2)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   chebyshev_feeder #(.WL(4), .CL(4), .WIDENING(0), .N_COEFF(1), .LAT(2)) dut1 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_coeff(input logic [3:0] addr, input logic signed [3:0] data);
      bus.coeff_we = 1'b1; bus.coeff_addr = addr; bus.coeff_wdata = data;
      if (addr < 4'd4) tab[int'(addr)] = data;
      tick();
      bus.coeff_we = 1'b0;
   endtask

   // One evaluation: start at cycle 0, terms at cycles 1..4, result_in valid
   // only at cycle 6, done expected at cycle 7.  mode 1 = random noise while
   // busy, mode 2 = start plus write addr1/data3 held while busy.
   task automatic do_eval(input logic signed [3:0] x, input logic signed [11:0] r,
                          input bit wr, input logic [3:0] waddr,
                          input logic signed [3:0] wdata, input int mode);
      logic signed [3:0]  exp_c [4];
      logic signed [11:0] junk;
      junk = ~r;
      if (wr && waddr < 4'd4) tab[int'(waddr)] = wdata;
      for (int i = 0; i < 4; i++) exp_c[i] = tab[3 - i];
      bus.start = 1'b1; bus.x_in = x; bus.coeff_we = wr;
      bus.coeff_addr = waddr; bus.coeff_wdata = wdata; bus.result_in = junk;
      tick();
      for (int c = 1; c <= 7; c++) begin
         bus.start = 1'b0; bus.coeff_we = 1'b0;
         if (mode == 1 && c < 7) begin
            bus.start = 1'($urandom_range(0, 1)); bus.x_in = 4'($urandom);
            bus.coeff_we = 1'($urandom_range(0, 1));
            bus.coeff_addr = 4'($urandom_range(0, 5)); bus.coeff_wdata = 4'($urandom);
         end else if (mode == 2 && c < 7) begin
            bus.start = 1'b1; bus.x_in = 4'($urandom);
            bus.coeff_we = 1'b1; bus.coeff_addr = 4'd1; bus.coeff_wdata = 4'sd3;
         end
         bus.result_in = (c == 6) ? r : junk;
         total++;
         if (bus.feed_valid !== (c <= 4)) begin
            bad++; $display("FAIL feed_valid c=%0d got %b want %b", c, bus.feed_valid, (c <= 4));
         end
         total++;
         if (c <= 4) begin
            if (bus.data_out !== x || bus.coeff_out !== exp_c[c-1]) begin
               bad++; $display("FAIL feed_term c=%0d got x=%h k=%h want x=%h k=%h",
                               c, bus.data_out, bus.coeff_out, x, exp_c[c-1]);
            end
         end else if (bus.data_out !== 4'sd0 || bus.coeff_out !== 4'sd0) begin
            bad++; $display("FAIL feed_idle c=%0d got x=%h k=%h want 0", c, bus.data_out, bus.coeff_out);
         end
         total++;
         if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL busy c=%0d got %b want 1", c, bus.busy);
         end
         total++;
         if (bus.done !== (c == 7)) begin
            bad++; $display("FAIL done c=%0d got %b want %b", c, bus.done, (c == 7));
         end
         if (c == 7) begin
            total++;
            if (bus.result !== r) begin
               bad++; $display("FAIL result got %h want %h", bus.result, r);
            end
         end
         tick();
      end
      bus.start = 1'b0; bus.coeff_we = 1'b0;
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== r) begin
         bad++; $display("FAIL after_done got done=%b busy=%b res=%h want 0 0 %h",
                         bus.done, bus.busy, bus.result, r);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 0; bus.x_in = 0; bus.coeff_we = 0; bus.coeff_addr = 0;
      bus.coeff_wdata = 0; bus.result_in = 0;
      bus1.start = 0; bus1.x_in = 0; bus1.coeff_we = 0; bus1.coeff_addr = 0;
      bus1.coeff_wdata = 0; bus1.result_in = 0;
      for (int i = 0; i < 4; i++) tab[i] = 4'sd0;
      tab1 = 4'sd0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      total++;
      if ({bus.busy, bus.done, bus.feed_valid} !== 3'b000 || bus.data_out !== 4'sd0 ||
          bus.coeff_out !== 4'sd0 || bus.result !== 12'sd0) begin
         bad++; $display("FAIL reset_state got busy=%b done=%b fv=%b x=%h k=%h res=%h want all 0",
                         bus.busy, bus.done, bus.feed_valid, bus.data_out, bus.coeff_out, bus.result);
      end
      total++;
      if ({bus1.busy, bus1.done, bus1.feed_valid} !== 3'b000 || bus1.result !== 12'sd0) begin
         bad++; $display("FAIL reset_state_n1 got busy=%b done=%b fv=%b res=%h want 0",
                         bus1.busy, bus1.done, bus1.feed_valid, bus1.result);
      end
      // Table must come out of reset as zeros.
      do_eval(4'sd3, 12'sh123, 1'b0, 4'd0, 4'sd0, 0);
   endtask

   task automatic test_basic();
      write_coeff(4'd0, 4'sd2);
      write_coeff(4'd1, 4'sd5);
      write_coeff(4'd2, 4'sd0);
      write_coeff(4'd3, 4'sd1);
      write_coeff(4'd9, 4'sd7);
      do_eval(4'sd4, 12'sh0A5, 1'b0, 4'd0, 4'sd0, 0);
   endtask

   task automatic test_busy_ignore();
      do_eval(4'sd4, 12'sh3C1, 1'b0, 4'd0, 4'sd0, 2);
      do_eval(-4'sd2, 12'sh7FE, 1'b0, 4'd0, 4'sd0, 0);
   endtask

   task automatic test_write_concurrent();
      do_eval(4'sd4, 12'sh0A5, 1'b1, 4'd1, 4'sd3, 0);
   endtask

   task automatic test_reset_mid();
      bus.start = 1'b1; bus.x_in = 4'sd5; bus.result_in = 12'sh555;
      tick();
      bus.start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      #1;
      total++;
      if ({bus.busy, bus.done, bus.feed_valid} !== 3'b000 || bus.data_out !== 4'sd0 ||
          bus.coeff_out !== 4'sd0 || bus.result !== 12'sd0) begin
         bad++; $display("FAIL reset_mid got busy=%b done=%b fv=%b x=%h k=%h res=%h want all 0",
                         bus.busy, bus.done, bus.feed_valid, bus.data_out, bus.coeff_out, bus.result);
      end
      for (int i = 0; i < 4; i++) tab[i] = 4'sd0;
      tab1 = 4'sd0;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         total++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_abort c=%0d got done=%b busy=%b want 0 0", c, bus.done, bus.busy);
         end
         tick();
      end
      do_eval(4'($urandom), 12'($urandom), 1'b1, 4'($urandom_range(0, 3)), 4'($urandom), 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 12; n++) begin
         for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
            write_coeff(4'($urandom_range(0, 7)), 4'($urandom));
         end
         do_eval(4'($urandom), 12'($urandom), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 6)), 4'($urandom), int'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   task automatic test_ncoeff1();
      logic signed [11:0] r1;
      r1 = 12'($urandom);
      bus1.coeff_we = 1'b1; bus1.coeff_addr = 4'd0; bus1.coeff_wdata = -4'sd1;
      tab1 = -4'sd1;
      tick();
      bus1.coeff_we = 1'b0;
      bus1.start = 1'b1; bus1.x_in = 4'sd7; bus1.result_in = ~r1;
      tick();
      bus1.start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         bus1.result_in = (c == 3) ? r1 : ~r1;
         total++;
         if (c == 1) begin
            if (bus1.feed_valid !== 1'b1 || bus1.coeff_out !== tab1 || bus1.data_out !== 4'sd7) begin
               bad++; $display("FAIL n1_feed got fv=%b k=%h x=%h want 1 %h 7",
                               bus1.feed_valid, bus1.coeff_out, bus1.data_out, tab1);
            end
         end else if (bus1.feed_valid !== 1'b0) begin
            bad++; $display("FAIL n1_fv c=%0d got %b want 0", c, bus1.feed_valid);
         end
         total++;
         if (bus1.done !== (c == 4) || bus1.busy !== (c <= 4)) begin
            bad++; $display("FAIL n1_done c=%0d got done=%b busy=%b want %b %b",
                            c, bus1.done, bus1.busy, (c == 4), (c <= 4));
         end
         if (c == 4) begin
            total++;
            if (bus1.result !== r1) begin
               bad++; $display("FAIL n1_result got %h want %h", bus1.result, r1);
            end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_busy_ignore();
      test_write_concurrent();
      test_reset_mid();
      test_random();
      test_ncoeff1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/chebyshev_feeder.md
CHEBYSHEV_FEEDER -- requirements
Module: chebyshev_feeder

Interface
REQ-001 Parameter WL, default 4: word length of sample x (data_in of chebyshev_computation).
REQ-002 Parameter CL, default 4: coefficient word length.
REQ-003 Parameter WIDENING, default 0: extra result bits; OUT = 2*WL+CL+WIDENING.
REQ-004 Parameter N_COEFF, default 4: number of coefficients streamed per evaluation (1..16).
REQ-005 Parameter LAT, default 2: cycles from last coefficient presented to valid result_in.
REQ-006 clock  in  1  single clock; all flops on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to evaluate with x_in.
REQ-009 x_in  in  WL signed  sample, sampled on accepted start.
REQ-010 coeff_we  in  1  coefficient table write enable.
REQ-011 coeff_addr  in  4  coefficient table index.
REQ-012 coeff_wdata  in  CL signed  coefficient write data.
REQ-013 data_out  out  WL signed  sample driven to computation.
REQ-014 coeff_out  out  CL signed  coefficient driven to computation.
REQ-015 feed_valid  out  1  high while data_out/coeff_out carry a term.
REQ-016 result_in  in  OUT signed  computation output.
REQ-017 result  out  OUT signed  captured evaluation result.
REQ-018 busy  out  1  high from accepted start until done.
REQ-019 done  out  1  one-cycle pulse when result is updated.

Function
REQ-020 FSM states SHALL be IDLE, FEED, WAIT, CAPTURE; IDLE->FEED on start; FEED->WAIT after N_COEFF feed cycles; WAIT->CAPTURE after LAT cycles; CAPTURE->IDLE unconditionally.
REQ-021 start SHALL be accepted only in IDLE; start in any other state SHALL be ignored.
REQ-022 On accepted start, x_in SHALL be registered and held on data_out for the whole FEED state.
REQ-023 In FEED, coeff_out SHALL present table entries N_COEFF-1 down to 0, one per cycle, with feed_valid=1 (Clenshaw order).
REQ-024 Outside FEED, feed_valid, data_out and coeff_out SHALL be 0.
REQ-025 In CAPTURE, result SHALL load result_in and done SHALL pulse for exactly one cycle; result SHALL hold until the next CAPTURE.
REQ-026 Latency start-to-done SHALL be exactly N_COEFF+LAT+1 cycles.
REQ-027 Table writes SHALL take effect in IDLE only; writes while busy SHALL be dropped; addr >= N_COEFF SHALL be ignored.
REQ-028 Write and start in the same IDLE cycle: write SHALL complete and the evaluation SHALL use the new value.
REQ-029 N_COEFF=1: FEED SHALL last one cycle.
REQ-030 Term counter SHALL be ceil(log2(N_COEFF+1)) bits and SHALL not wrap inside FEED.

Reset
REQ-031 Reset SHALL force IDLE, busy=0, done=0, feed_valid=0, data_out=0, coeff_out=0, result=0, coefficient table=0, asynchronously.
REQ-032 Reset mid-operation SHALL abort the evaluation without a done pulse; first start after release SHALL behave as from power-up.

Structure
REQ-033 Shared package chebyshev_pkg SHALL hold the FSM state encoding and the OUT width function.
REQ-034 Coefficient table SHALL be a sub-module chebyshev_coeff_regfile (N_COEFF x CL, one write, one async read).

Verification
REQ-035 Table {c0..c3}={2,5,0,1}, start with x=4 -> coeff_out sequence 1,0,5,2 with feed_valid=1 four cycles, data_out=4.
REQ-036 Stub computation returning 12'h0A5 -> result=0x0A5, done one pulse exactly 7 cycles after start (N_COEFF=4, LAT=2).
REQ-037 start asserted again during FEED/WAIT -> ignored, single done, busy stays high throughout.
REQ-038 coeff_we addr 1 data 3 during busy -> table unchanged; same write in IDLE concurrent with start -> coeff_out sequence 1,0,3,2.
REQ-039 reset pulsed in WAIT -> all outputs 0 immediately, no done; new start completes normally.
REQ-040 N_COEFF=1 build, c0=-1, x=7 -> one feed cycle coeff_out=4'hF, done 4 cycles after start.
